// File: rtl/bus_target_decoder.sv
// Purpose: target-side decoder behind the bus arbiter; selects one target, waits for its ack, commits writes / returns reads.
// Latency: tgt_sel one clock after the addressvalid rise, TargetReady two clocks after tgt_sel with ack tied high; strobes one clock after DataStrobe.
// Backpressure: TargetReady holds until DataStrobe; Error, DataStrobe before ack, or addressvalid falling aborts to DONE with no strobes.
module bus_target_decoder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TARGET_NUMBER  = 4,
  parameter int TARGET_SEL_LSB = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              addressvalid,
  input  logic [ADDR_WIDTH-1:0]             bus_addr,
  input  logic                              bus_wr,
  input  logic [DATA_WIDTH-1:0]             bus_wdata,
  output logic                              TargetReady,
  input  logic                              DataStrobe,
  input  logic                              Error,
  output logic [TARGET_NUMBER-1:0]          tgt_sel,
  input  logic [TARGET_NUMBER-1:0]          tgt_ack,
  output logic [TARGET_SEL_LSB-1:0]         tgt_addr,
  output logic [DATA_WIDTH-1:0]             tgt_wdata,
  output logic [TARGET_NUMBER-1:0]          tgt_wr_strobe,
  input  logic [TARGET_NUMBER*DATA_WIDTH-1:0] tgt_rdata,
  output logic [DATA_WIDTH-1:0]             bus_rdata,
  output logic                              rdata_valid,
  output logic                              err_sticky,
  output logic [ADDR_WIDTH-1:0]             err_addr,
  input  logic                              err_clear
);

  localparam int IDX_WIDTH = ADDR_WIDTH - TARGET_SEL_LSB;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACK,
    READY,
    DONE
  } state_t;

  state_t                  state;
  logic                    avD;
  logic                    wrQ;
  logic [ADDR_WIDTH-1:0]   addrQ;

  logic [IDX_WIDTH-1:0]     idx;
  logic [TARGET_NUMBER-1:0] decSel;
  logic                     cycleStart;
  logic                     ackHit;
  logic                     abortReq;
  logic [DATA_WIDTH-1:0]    rdMux;

  assign idx        = bus_addr[ADDR_WIDTH-1:TARGET_SEL_LSB];
  assign cycleStart = addressvalid & ~avD;
  // tgt_sel is already the one-hot of the captured index (all-zero when unmapped),
  // so masking with it picks only the selected target's ack and never matches for unmapped.
  assign ackHit     = |(tgt_ack & tgt_sel);
  assign abortReq   = ~addressvalid | Error | DataStrobe;

  // One-hot decode of the index field; an out-of-range index yields all zeros (unmapped).
  always_comb begin
    decSel = '0;
    for (int i = 0; i < TARGET_NUMBER; i++) begin
      decSel[i] = (idx == IDX_WIDTH'(i));
    end
  end

  // Read-data mux driven by the held one-hot select.
  always_comb begin
    rdMux = '0;
    for (int i = 0; i < TARGET_NUMBER; i++) begin
      if (tgt_sel[i]) begin
        rdMux = rdMux | tgt_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer FSM with registered outputs; strobes default to a single clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      avD           <= 1'b0;
      wrQ           <= 1'b0;
      addrQ         <= '0;
      TargetReady   <= 1'b0;
      tgt_sel       <= '0;
      tgt_addr      <= '0;
      tgt_wdata     <= '0;
      tgt_wr_strobe <= '0;
      bus_rdata     <= '0;
      rdata_valid   <= 1'b0;
    end else begin
      avD           <= addressvalid;
      tgt_wr_strobe <= '0;
      rdata_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (cycleStart) begin
            addrQ     <= bus_addr;
            wrQ       <= bus_wr;
            tgt_addr  <= bus_addr[TARGET_SEL_LSB-1:0];
            tgt_wdata <= bus_wdata;
            tgt_sel   <= decSel;
            // Unmapped skips the settle clock and parks until the arbiter times out.
            state     <= (|decSel) ? SELECT : WAIT_ACK;
          end
        end
        SELECT: begin
          if (abortReq) begin
            tgt_sel <= '0;
            state   <= DONE;
          end else begin
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Abort has priority over a coincident ack.
          if (abortReq) begin
            tgt_sel <= '0;
            state   <= DONE;
          end else if (ackHit) begin
            TargetReady <= 1'b1;
            if (!wrQ) begin
              bus_rdata <= rdMux;
            end
            state <= READY;
          end
        end
        READY: begin
          if (!addressvalid || Error) begin
            TargetReady <= 1'b0;
            tgt_sel     <= '0;
            state       <= DONE;
          end else if (DataStrobe) begin
            // tgt_sel stays up for the strobe clock and drops in DONE.
            TargetReady <= 1'b0;
            if (wrQ) begin
              tgt_wr_strobe <= tgt_sel;
            end else begin
              rdata_valid <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          TargetReady <= 1'b0;
          tgt_sel     <= '0;
          if (!addressvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky time-out record; the first failing address is kept, and a set beats a coincident clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (Error) begin
      err_sticky <= 1'b1;
      if (!err_sticky) begin
        err_addr <= addrQ;
      end
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end
  end

endmodule

// File: tb/tb_bus_target_decoder.sv
// Purpose: self-checking bench for bus_target_decoder: vector table, hand-written corner sequences, randomized transactions.
// Latency: n/a (bench).
// Backpressure: the bench plays the arbiter; it waits a bounded number of clocks for TargetReady, then times out.
module tb_bus_target_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        addressvalid;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic        TargetReady;
  logic        DataStrobe;
  logic        Error;
  logic [3:0]  tgt_sel;
  logic [3:0]  tgt_ack;
  logic [11:0] tgt_addr;
  logic [15:0] tgt_wdata;
  logic [3:0]  tgt_wr_strobe;
  logic [63:0] tgt_rdata;
  logic [15:0] bus_rdata;
  logic        rdata_valid;
  logic        err_sticky;
  logic [15:0] err_addr;
  logic        err_clear;

  always #5 clock = ~clock;

  bus_target_decoder dut (
    .clock(clock), .reset(reset), .addressvalid(addressvalid), .bus_addr(bus_addr),
    .bus_wr(bus_wr), .bus_wdata(bus_wdata), .TargetReady(TargetReady), .DataStrobe(DataStrobe),
    .Error(Error), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_wr_strobe(tgt_wr_strobe), .tgt_rdata(tgt_rdata),
    .bus_rdata(bus_rdata), .rdata_valid(rdata_valid), .err_sticky(err_sticky),
    .err_addr(err_addr), .err_clear(err_clear)
  );

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    int          delay;
    bit          never;
    int          hold;
    bit          clrBefore;
    logic [3:0]  expSel;
    logic [3:0]  expWrStb;
    bit          expRdv;
    logic [15:0] expRdata;
    bit          expTr;
    bit          expSticky;
    logic [15:0] expEaddr;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // target responder knobs
  int          ackDelay = 0;
  bit          ackNever = 1'b1;
  logic [3:0]  ackNoise = 4'b0;
  int          selCnt   = 0;
  logic [15:0] tgtData[4];

  // observations over one transaction
  logic [3:0]  oSel;
  logic [3:0]  oWrVal;
  int          oWrCnt;
  int          oRdvCnt;
  int          oBad;
  int          oTrDrop;
  logic        oTrSeen;
  logic [15:0] oRdVal;

  // reference error record
  bit          mSticky;
  logic [15:0] mEaddr;

  // Target responder: selected target acks once selected for more than ackDelay clocks;
  // unselected ack lines carry noise that must be ignored.
  always @(negedge clock) begin
    if (tgt_sel != 4'b0) selCnt++;
    else selCnt = 0;
    tgt_ack = ((!ackNever && selCnt > ackDelay) ? tgt_sel : 4'b0) | (ackNoise & ~tgt_sel);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic setRdata(input int i, input logic [15:0] v);
    tgtData[i] = v;
    tgt_rdata[i*16 +: 16] = v;
  endtask

  task automatic clearObs();
    oSel = 4'b0; oWrVal = 4'b0; oWrCnt = 0; oRdvCnt = 0; oBad = 0; oTrDrop = 0;
    oTrSeen = 1'b0; oRdVal = 16'h0;
  endtask

  task automatic sample();
    oSel = oSel | tgt_sel;
    if (tgt_wr_strobe != 4'b0) begin oWrCnt++; oWrVal = tgt_wr_strobe; end
    if (rdata_valid) begin oRdvCnt++; oRdVal = bus_rdata; end
    if ((tgt_wr_strobe != 4'b0 || rdata_valid) && tgt_sel == 4'b0) oBad++;
    oTrSeen = oTrSeen | TargetReady;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".TargetReady"}, TargetReady, 0);
    check({tag, ".tgt_sel"}, tgt_sel, 0);
    check({tag, ".tgt_wr_strobe"}, tgt_wr_strobe, 0);
    check({tag, ".rdata_valid"}, rdata_valid, 0);
    check({tag, ".bus_rdata"}, bus_rdata, 0);
    check({tag, ".tgt_addr"}, tgt_addr, 0);
    check({tag, ".tgt_wdata"}, tgt_wdata, 0);
    check({tag, ".err_sticky"}, err_sticky, 0);
    check({tag, ".err_addr"}, err_addr, 0);
  endtask

  task automatic clearErr(input string tag);
    @(negedge clock); err_clear = 1'b1;
    @(negedge clock); err_clear = 1'b0;
    check({tag, ".clr_sticky"}, err_sticky, 0);
    check({tag, ".clr_addr"}, err_addr, 0);
    mSticky = 1'b0; mEaddr = 16'h0;
  endtask

  // Plays the arbiter for one transfer: raise addressvalid, wait (bounded) for TargetReady,
  // strobe (or strobe+Error on time-out), then drop addressvalid.
  task automatic runTxn(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                        input int delay, input bit never, input int hold, input bit clrWithErr);
    bit got;
    clearObs();
    @(negedge clock);
    bus_addr = addr; bus_wr = wr; bus_wdata = wdata;
    ackDelay = delay; ackNever = never; addressvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock); sample(); got = TargetReady;
    end
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clock); sample();
        if (!TargetReady) oTrDrop++;
      end
    end
    DataStrobe = 1'b1; Error = !got; err_clear = clrWithErr && !got;
    @(negedge clock); sample();
    DataStrobe = 1'b0; Error = 1'b0; err_clear = 1'b0; addressvalid = 1'b0;
    repeat (3) begin @(negedge clock); sample(); end
  endtask

  task automatic checkTxn(input string tag, input vec_t v);
    check({tag, ".sel"}, oSel, v.expSel);
    check({tag, ".wr_strobe"}, oWrVal, v.expWrStb);
    check({tag, ".wr_count"}, oWrCnt, (v.expWrStb != 4'b0) ? 1 : 0);
    check({tag, ".rdv_count"}, oRdvCnt, v.expRdv);
    if (v.expRdv) check({tag, ".bus_rdata"}, oRdVal, v.expRdata);
    check({tag, ".target_ready"}, oTrSeen, v.expTr);
    check({tag, ".ready_drop"}, oTrDrop, 0);
    check({tag, ".strobe_without_sel"}, oBad, 0);
    check({tag, ".err_sticky"}, err_sticky, v.expSticky);
    check({tag, ".err_addr"}, err_addr, v.expEaddr);
    check({tag, ".tgt_addr"}, tgt_addr, {20'h0, v.addr[11:0]});
    check({tag, ".tgt_wdata"}, tgt_wdata, v.wdata);
  endtask

  task automatic runVec(input string tag, input vec_t v);
    if (v.clrBefore) clearErr(tag);
    runTxn(v.addr, v.wr, v.wdata, v.delay, v.never, v.hold, 1'b0);
    checkTxn(tag, v);
  endtask

  initial begin
    vec_t vecs[9];
    vec_t rv;
    bit   got;
    bit   ok;
    logic [3:0] ridx;

    // addr  wr wdata delay never hold clr | sel wstb rdv rdata tr sticky eaddr
    vecs[0] = '{16'h2034, 1, 16'hA5A5, 3, 0, 2, 0, 4'b0100, 4'b0100, 0, 16'h0000, 1, 0, 16'h0000};
    vecs[1] = '{16'h1000, 0, 16'h0000, 0, 0, 0, 0, 4'b0010, 4'b0000, 1, 16'h1234, 1, 0, 16'h0000};
    vecs[2] = '{16'h5000, 1, 16'h5555, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 1, 16'h5000};
    vecs[3] = '{16'h0040, 0, 16'h0000, 0, 1, 0, 1, 4'b0001, 4'b0000, 0, 16'h0000, 0, 1, 16'h0040};
    vecs[4] = '{16'h3010, 1, 16'h7777, 0, 1, 0, 0, 4'b1000, 4'b0000, 0, 16'h0000, 0, 1, 16'h0040};
    vecs[5] = '{16'h2FFF, 0, 16'h0000, 1, 0, 0, 1, 4'b0100, 4'b0000, 1, 16'hC2C2, 1, 0, 16'h0000};
    vecs[6] = '{16'h3FFE, 1, 16'hBEEF, 0, 0, 1, 0, 4'b1000, 4'b1000, 0, 16'h0000, 1, 0, 16'h0000};
    vecs[7] = '{16'hF123, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 1, 16'hF123};
    vecs[8] = '{16'h0ABC, 1, 16'h1357, 2, 0, 0, 1, 4'b0001, 4'b0001, 0, 16'h0000, 1, 0, 16'h0000};

    reset = 1'b1; addressvalid = 1'b0; bus_addr = 16'h0; bus_wr = 1'b0; bus_wdata = 16'h0;
    DataStrobe = 1'b0; Error = 1'b0; err_clear = 1'b0; tgt_rdata = 64'h0;
    setRdata(0, 16'hB0B0); setRdata(1, 16'h1234); setRdata(2, 16'hC2C2); setRdata(3, 16'hD3D3);
    mSticky = 1'b0; mEaddr = 16'h0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;

    // vector table, with noise on every non-selected ack line
    ackNoise = 4'hF;
    for (int i = 0; i < 9; i++) runVec($sformatf("vec%0d", i), vecs[i]);
    ackNoise = 4'h0;

    // exact latency with ack high as soon as selected
    @(negedge clock);
    bus_addr = 16'h1100; bus_wr = 1'b1; bus_wdata = 16'h0F0F; ackNever = 1'b0; ackDelay = 0;
    addressvalid = 1'b1;
    @(negedge clock);
    check("lat.sel_rise", tgt_sel, 4'b0010);
    check("lat.ready_c1", TargetReady, 0);
    @(negedge clock);
    check("lat.ready_c2", TargetReady, 0);
    @(negedge clock);
    check("lat.ready_c3", TargetReady, 1);
    check("lat.no_early_strobe", tgt_wr_strobe, 0);
    DataStrobe = 1'b1;
    @(negedge clock);
    DataStrobe = 1'b0;
    check("lat.strobe", tgt_wr_strobe, 4'b0010);
    check("lat.strobe_sel", tgt_sel, 4'b0010);
    check("lat.ready_drop", TargetReady, 0);
    addressvalid = 1'b0;
    @(negedge clock);
    check("lat.strobe_end", tgt_wr_strobe, 0);
    check("lat.sel_off", tgt_sel, 0);
    repeat (2) @(negedge clock);

    // reset while READY to target 3
    runTxn(16'h6000, 1'b1, 16'h1111, 0, 1'b1, 0, 1'b0);
    @(negedge clock);
    bus_addr = 16'h3456; bus_wr = 1'b1; bus_wdata = 16'hCAFE; ackNever = 1'b0; ackDelay = 0;
    addressvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clock); got = TargetReady; end
    check("rst.reached_ready", got, 1);
    reset = 1'b1; addressvalid = 1'b0;
    @(negedge clock);
    checkAllZero("rst");
    reset = 1'b0;
    clearObs();
    repeat (3) begin @(negedge clock); sample(); end
    check("rst.no_strobe_after", oWrCnt, 0);
    mSticky = 1'b0; mEaddr = 16'h0;
    rv = '{16'h1008, 0, 16'h2222, 0, 0, 0, 0, 4'b0010, 4'b0000, 1, 16'h1234, 1, 0, 16'h0000};
    runVec("rst.next", rv);

    // ack and Error in the same WAIT_ACK clock
    clearObs();
    @(negedge clock);
    bus_addr = 16'h2100; bus_wr = 1'b0; ackNever = 1'b0; ackDelay = 0; addressvalid = 1'b1;
    @(negedge clock); sample();
    @(negedge clock); sample();
    Error = 1'b1; DataStrobe = 1'b1;
    @(negedge clock); sample();
    Error = 1'b0; DataStrobe = 1'b0;
    check("ackerr.ready", TargetReady, 0);
    check("ackerr.sel", tgt_sel, 0);
    check("ackerr.sticky", err_sticky, 1);
    check("ackerr.eaddr", err_addr, 16'h2100);
    addressvalid = 1'b0;
    repeat (3) begin @(negedge clock); sample(); end
    check("ackerr.rdv", oRdvCnt, 0);
    check("ackerr.ready_seen", oTrSeen, 0);

    // addressvalid dropped in WAIT_ACK; IDLE must be reached within two clocks
    clearObs();
    @(negedge clock);
    bus_addr = 16'h1200; bus_wr = 1'b1; ackNever = 1'b1; addressvalid = 1'b1;
    @(negedge clock); sample();
    @(negedge clock); sample();
    addressvalid = 1'b0;
    @(negedge clock); sample();
    check("drop.sel", tgt_sel, 0);
    @(negedge clock); sample();
    bus_addr = 16'h3000; bus_wr = 1'b0; ackNever = 1'b0; addressvalid = 1'b1;
    @(negedge clock); sample();
    check("drop.restart_sel", tgt_sel, 4'b1000);
    addressvalid = 1'b0;
    repeat (3) begin @(negedge clock); sample(); end
    check("drop.no_strobe", oWrCnt + oRdvCnt, 0);

    // clear, then clear coincident with Error
    clearErr("clr");
    rv = '{16'h0200, 1, 16'h3333, 0, 1, 0, 0, 4'b0001, 4'b0000, 0, 16'h0000, 0, 1, 16'h0200};
    runTxn(rv.addr, rv.wr, rv.wdata, rv.delay, rv.never, rv.hold, 1'b1);
    checkTxn("clr_err", rv);

    // randomized transactions against the transaction-level model
    clearErr("rnd.start");
    for (int n = 0; n < 40; n++) begin
      ridx = 4'($urandom_range(0, 6));
      rv.addr      = {ridx, 12'($urandom)};
      rv.wr        = 1'($urandom);
      rv.wdata     = 16'($urandom);
      rv.delay     = $urandom_range(0, 3);
      rv.never     = ($urandom_range(0, 4) == 0);
      rv.hold      = $urandom_range(0, 2);
      rv.clrBefore = ($urandom_range(0, 7) == 0);
      ackNoise     = 4'($urandom);
      for (int i = 0; i < 4; i++) setRdata(i, 16'($urandom));
      if (rv.clrBefore) clearErr($sformatf("rnd%0d", n));
      ok           = (ridx < 4) && !rv.never;
      rv.expSel    = (ridx < 4) ? 4'(1 << ridx) : 4'b0;
      rv.expWrStb  = (ok && rv.wr) ? rv.expSel : 4'b0;
      rv.expRdv    = ok && !rv.wr;
      rv.expRdata  = (ridx < 4) ? tgtData[ridx[1:0]] : 16'h0;
      rv.expTr     = ok;
      if (!ok) begin
        if (!mSticky) mEaddr = rv.addr;
        mSticky = 1'b1;
      end
      rv.expSticky = mSticky;
      rv.expEaddr  = mEaddr;
      runTxn(rv.addr, rv.wr, rv.wdata, rv.delay, rv.never, rv.hold, 1'b0);
      checkTxn($sformatf("rnd%0d", n), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_target_decoder.md
Name: bus_target_decoder

Overview:
Target-side companion to the bus arbiter; sits directly downstream of it.
- Consumes `addressvalid`, `DataStrobe` and `Error`; returns `TargetReady`.
- Decodes the granted master's address into a one-hot target select and waits for the selected target's acknowledge.
- On `DataStrobe`, commits the write to the target or returns its read data to the bus.
- Aborts cleanly on arbiter time-out and records the failing address.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- TARGET_NUMBER, 4, number of target devices (≥2).
- TARGET_SEL_LSB, 12, lowest address bit of the target index field `bus_addr[ADDR_WIDTH-1:TARGET_SEL_LSB]`.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- addressvalid  in  1  from arbiter: granted master's address/data are stable
- bus_addr  in  ADDR_WIDTH  muxed master address
- bus_wr  in  1  1 = write, 0 = read
- bus_wdata  in  DATA_WIDTH  muxed master write data
- TargetReady  out  1  to arbiter: selected target acknowledged
- DataStrobe  in  1  from arbiter: one-clock transfer strobe (target ready or time-out)
- Error  in  1  from arbiter: one-clock time-out marker
- tgt_sel  out  TARGET_NUMBER  one-hot target chip select
- tgt_ack  in  TARGET_NUMBER  per-target acknowledge
- tgt_addr  out  TARGET_SEL_LSB  captured offset `bus_addr[TARGET_SEL_LSB-1:0]`
- tgt_wdata  out  DATA_WIDTH  captured write data
- tgt_wr_strobe  out  TARGET_NUMBER  one-clock write commit, one-hot
- tgt_rdata  in  TARGET_NUMBER*DATA_WIDTH  packed read data; target i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- bus_rdata  out  DATA_WIDTH  read data returned to master
- rdata_valid  out  1  one-clock qualifier for `bus_rdata`
- err_sticky  out  1  time-out seen since last clear
- err_addr  out  ADDR_WIDTH  address of the first failing cycle since last clear
- err_clear  in  1  clears `err_sticky` and `err_addr`

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - State → IDLE.
  - All outputs are 0: `TargetReady`, `tgt_sel`, `tgt_wr_strobe`, `rdata_valid`, `bus_rdata`, `tgt_addr`, `tgt_wdata`, `err_sticky`, `err_addr`.
  - Reset mid-cycle abandons the transfer. No strobe is issued.
- `addressvalid` is registered (`av_d`). The cycle start is `addressvalid & ~av_d`, sampled in IDLE only.
- Decode: `idx = bus_addr[ADDR_WIDTH-1:TARGET_SEL_LSB]`. If `idx >= TARGET_NUMBER`, the address is unmapped.
- FSM states: IDLE, SELECT, WAIT_ACK, READY, DONE.
  - IDLE: on cycle start, capture `bus_addr`, `bus_wr`, `bus_wdata` and `idx`.
    - Mapped: assert `tgt_sel[idx]` and go to SELECT.
    - Unmapped: `tgt_sel` stays 0; go to WAIT_ACK. `TargetReady` is never raised and the arbiter times out.
  - SELECT: a one-clock settle for the target. Go to WAIT_ACK.
  - WAIT_ACK: sample `tgt_ack[idx]`; other ack bits are ignored.
    - Ack = 1: register `TargetReady` = 1. For a read, capture `tgt_rdata[idx]` into `bus_rdata`. Go to READY.
  - READY: hold `TargetReady` = 1 and `tgt_sel` until `DataStrobe`.
    - Write: pulse `tgt_wr_strobe[idx]` for one clock.
    - Read: pulse `rdata_valid` for one clock.
    - Then go to DONE.
  - DONE: `TargetReady` = 0, `tgt_sel` = 0. Return to IDLE when `addressvalid` = 0.
- Latency, with `tgt_ack` tied high: `tgt_sel` rises the clock after the start edge, and `TargetReady` rises 2 clocks after `tgt_sel`.
- Strobes are registered:
  - They are asserted for the clock after the edge that samples `DataStrobe`.
  - They never coincide with `tgt_sel` = 0.
- Abort: `DataStrobe` or `Error` sampled in SELECT or WAIT_ACK goes to DONE. No write strobe, no `rdata_valid`.
- `Error` handling:
  - `Error` in any non-IDLE state aborts to DONE.
  - `Error` sets `err_sticky`.
  - `err_addr` loads only if `err_sticky` was 0 (first error kept).
  - `Error` and `err_clear` in the same clock: set wins.
- Ack and `Error` in the same WAIT_ACK clock: `Error` wins (abort).
- `DataStrobe` and `Error` together in READY: abort, no commit.
- `addressvalid` falling in any non-IDLE state (arbiter `End_Cycle`) forces DONE → IDLE. No strobes are issued after the fall.
- A new cycle start is ignored outside IDLE. The back-to-back minimum is one IDLE clock.
- A late ack arriving in DONE or IDLE is ignored.

Test Plan:
1. Write to target 2, `bus_addr`=0x2034, `bus_wdata`=0xA5A5, `tgt_ack[2]` high 3 clocks after `tgt_sel` → `tgt_sel`=4'b0100, `TargetReady`=1 until `DataStrobe`, a single `tgt_wr_strobe`=4'b0100 pulse, `tgt_addr`=0x034, `tgt_wdata`=0xA5A5.
2. Read from target 1, `bus_addr`=0x1000, `tgt_rdata[1]`=0x1234 with immediate ack → `bus_rdata`=0x1234, `rdata_valid` one clock after `DataStrobe`, no `tgt_wr_strobe`.
3. Unmapped `bus_addr`=0x5000 (idx 5) → `tgt_sel`=0, `TargetReady` stays 0. Drive `DataStrobe`+`Error` → `err_sticky`=1, `err_addr`=0x5000, no strobes.
4. Target 0 never acks, then a second time-out at 0x3010 → `err_addr` holds the first address. Pulse `err_clear` → `err_sticky`=0, `err_addr`=0. `err_clear` coincident with `Error` → `err_sticky`=1.
5. Assert `reset` in READY for target 3 → next clock `TargetReady`=0, `tgt_sel`=0, no `tgt_wr_strobe`. A new `addressvalid` rise is accepted normally.
6. Ack and `Error` in the same clock, and `addressvalid` dropped in WAIT_ACK → abort to DONE/IDLE, no `rdata_valid`, FSM back in IDLE within 2 clocks.
